// File: rtl/armleo_regfile_ctrl_if.sv
// Core, debug and regfile-side signals of the register file controller.
// slave = controller view, master = core/debug/regfile environment view.
interface armleo_regfile_ctrl_if #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH_LOG2 = 5
);
    // core side
    logic                  ready;
    logic                  rs1_req;
    logic                  rs2_req;
    logic [DEPTH_LOG2-1:0] rs1_addr;
    logic [DEPTH_LOG2-1:0] rs2_addr;
    logic [WIDTH-1:0]      rs1_rdata;
    logic [WIDTH-1:0]      rs2_rdata;
    logic                  rd_write;
    logic [DEPTH_LOG2-1:0] rd_addr;
    logic [WIDTH-1:0]      rd_wdata;

    // debug side
    logic                  dbg_req;
    logic                  dbg_write;
    logic [DEPTH_LOG2-1:0] dbg_addr;
    logic [WIDTH-1:0]      dbg_wdata;
    logic                  dbg_ack;
    logic [WIDTH-1:0]      dbg_rdata;

    // regfile side
    logic                  rf_rs1_read;
    logic                  rf_rs2_read;
    logic [DEPTH_LOG2-1:0] rf_rs1_addr;
    logic [DEPTH_LOG2-1:0] rf_rs2_addr;
    logic [WIDTH-1:0]      rf_rs1_rdata;
    logic [WIDTH-1:0]      rf_rs2_rdata;
    logic                  rf_rd_write;
    logic [DEPTH_LOG2-1:0] rf_rd_addr;
    logic [WIDTH-1:0]      rf_rd_wdata;

    modport slave (
        output ready,
        input  rs1_req, rs2_req, rs1_addr, rs2_addr,
        output rs1_rdata, rs2_rdata,
        input  rd_write, rd_addr, rd_wdata,
        input  dbg_req, dbg_write, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_rdata,
        output rf_rs1_read, rf_rs2_read, rf_rs1_addr, rf_rs2_addr,
        input  rf_rs1_rdata, rf_rs2_rdata,
        output rf_rd_write, rf_rd_addr, rf_rd_wdata
    );

    modport master (
        input  ready,
        output rs1_req, rs2_req, rs1_addr, rs2_addr,
        input  rs1_rdata, rs2_rdata,
        output rd_write, rd_addr, rd_wdata,
        output dbg_req, dbg_write, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_rdata,
        input  rf_rs1_read, rf_rs2_read, rf_rs1_addr, rf_rs2_addr,
        output rf_rs1_rdata, rf_rs2_rdata,
        input  rf_rd_write, rf_rd_addr, rf_rd_wdata
    );
endinterface

// File: rtl/armleo_regfile_ctrl.sv
// Register file controller: post-reset clear, core pass-through with write->read
// bypass, and arbitrated debug access with a starvation-forced grant.
module armleo_regfile_ctrl #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DEPTH_LOG2   = 5,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    armleo_regfile_ctrl_if.slave    bus
);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 2);
    localparam logic [DEPTH_LOG2-1:0] LAST_ADDR  = '1;
    localparam logic [DEPTH_LOG2-1:0] FIRST_ADDR = DEPTH_LOG2'(1);
    localparam logic [SW-1:0]         STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_CLEAR   = 2'd0,
        S_RUN     = 2'd1,
        S_DBG_ACK = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DEPTH_LOG2-1:0] r_clr_addr;
    logic [DEPTH_LOG2-1:0] w_clr_addr_nxt;
    logic [SW-1:0]         r_starve;
    logic [SW-1:0]         w_starve_nxt;

    logic                  r_byp1;
    logic                  r_byp2;
    logic [WIDTH-1:0]      r_byp_data1;
    logic [WIDTH-1:0]      r_byp_data2;
    logic                  r_dbg_rd;

    logic                  w_ready;
    logic                  w_force;
    logic                  w_grant_rd;
    logic                  w_grant_wr;
    logic                  w_rs1_read;
    logic                  w_rs2_read;
    logic [DEPTH_LOG2-1:0] w_rs1_addr;
    logic [DEPTH_LOG2-1:0] w_rs2_addr;
    logic                  w_rd_write;
    logic [DEPTH_LOG2-1:0] w_rd_addr;
    logic [WIDTH-1:0]      w_rd_wdata;
    logic                  w_hit1;
    logic                  w_hit2;
    logic [WIDTH-1:0]      w_rs1_rdata;
    logic [WIDTH-1:0]      w_rs2_rdata;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= FIRST_ADDR;
            r_starve   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
            r_starve   <= w_starve_nxt;
        end
    end

    // Next state, arbitration and regfile port steering
    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        w_starve_nxt   = r_starve;
        w_ready        = 1'b0;
        w_force        = 1'b0;
        w_grant_rd     = 1'b0;
        w_grant_wr     = 1'b0;
        w_rs1_read     = 1'b0;
        w_rs2_read     = 1'b0;
        w_rs1_addr     = bus.rs1_addr;
        w_rs2_addr     = bus.rs2_addr;
        w_rd_write     = 1'b0;
        w_rd_addr      = bus.rd_addr;
        w_rd_wdata     = bus.rd_wdata;

        case (r_state)
            S_CLEAR: begin
                w_rd_write = 1'b1;
                w_rd_addr  = r_clr_addr;
                w_rd_wdata = '0;
                if (r_clr_addr == LAST_ADDR) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_clr_addr_nxt = r_clr_addr + FIRST_ADDR;
                end
            end
            S_RUN: begin
                // A starved debug request steals the whole cycle from the core.
                w_force    = bus.dbg_req && (r_starve == STARVE_MAX);
                w_ready    = !w_force;
                w_grant_rd = bus.dbg_req && !bus.dbg_write && (!bus.rs1_req || !w_ready);
                w_grant_wr = bus.dbg_req &&  bus.dbg_write && (!bus.rd_write || !w_ready);
                if (w_grant_rd || w_grant_wr) begin
                    w_state_nxt  = S_DBG_ACK;
                    w_starve_nxt = '0;
                end else if (bus.dbg_req) begin
                    w_starve_nxt = r_starve + SW'(1);
                end
            end
            S_DBG_ACK: begin
                w_ready     = 1'b1;
                w_state_nxt = S_RUN;
            end
            default: begin
                w_state_nxt = S_CLEAR;
            end
        endcase

        if (w_ready) begin
            w_rs1_read = bus.rs1_req;
            w_rs2_read = bus.rs2_req;
            w_rd_write = bus.rd_write && (bus.rd_addr != '0);
        end
        if (w_grant_rd) begin
            w_rs1_read = 1'b1;
            w_rs1_addr = bus.dbg_addr;
        end
        if (w_grant_wr) begin
            w_rd_write = (bus.dbg_addr != '0);
            w_rd_addr  = bus.dbg_addr;
            w_rd_wdata = bus.dbg_wdata;
        end
    end

    // Register 0 never bypasses: its writes are never issued to the regfile.
    assign w_hit1 = w_rd_write && (w_rd_addr == w_rs1_addr) && (w_rs1_addr != '0);
    assign w_hit2 = w_rd_write && (w_rd_addr == w_rs2_addr) && (w_rs2_addr != '0);

    // Bypass selection is latched per port and held until that port reads again
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byp1      <= 1'b0;
            r_byp2      <= 1'b0;
            r_byp_data1 <= '0;
            r_byp_data2 <= '0;
            r_dbg_rd    <= 1'b0;
        end else begin
            if (w_rs1_read) begin
                r_byp1      <= w_hit1;
                r_byp_data1 <= w_rd_wdata;
            end
            if (w_rs2_read) begin
                r_byp2      <= w_hit2;
                r_byp_data2 <= w_rd_wdata;
            end
            if (w_grant_rd || w_grant_wr) begin
                r_dbg_rd <= w_grant_rd;
            end
        end
    end

    assign w_rs1_rdata = r_byp1 ? r_byp_data1 : bus.rf_rs1_rdata;
    assign w_rs2_rdata = r_byp2 ? r_byp_data2 : bus.rf_rs2_rdata;

    assign bus.ready       = w_ready;
    assign bus.rs1_rdata   = w_rs1_rdata;
    assign bus.rs2_rdata   = w_rs2_rdata;
    assign bus.dbg_ack     = (r_state == S_DBG_ACK);
    assign bus.dbg_rdata   = ((r_state == S_DBG_ACK) && r_dbg_rd) ? w_rs1_rdata : '0;
    assign bus.rf_rs1_read = w_rs1_read;
    assign bus.rf_rs2_read = w_rs2_read;
    assign bus.rf_rs1_addr = w_rs1_addr;
    assign bus.rf_rs2_addr = w_rs2_addr;
    assign bus.rf_rd_write = w_rd_write;
    assign bus.rf_rd_addr  = w_rd_addr;
    assign bus.rf_rd_wdata = w_rd_wdata;

endmodule

// File: tb/tb_armleo_regfile_ctrl.sv
// Bench for armleo_regfile_ctrl: synchronous regfile model on the rf side and an
// architectural register-array reference (reads see same-cycle writes).
module tb_armleo_regfile_ctrl;
    localparam int unsigned W     = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned LIMIT = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    armleo_regfile_ctrl_if #(.WIDTH(W), .DEPTH_LOG2(AW)) bus();

    armleo_regfile_ctrl #(.WIDTH(W), .DEPTH_LOG2(AW), .STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Regfile: synchronous read, old data on same-address same-cycle write
    logic [W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.rf_rs1_read) bus.rf_rs1_rdata <= mem[bus.rf_rs1_addr];
        if (bus.rf_rs2_read) bus.rf_rs2_rdata <= mem[bus.rf_rs2_addr];
        if (bus.rf_rd_write) mem[bus.rf_rd_addr] <= bus.rf_rd_wdata;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    logic [W-1:0]  arch [DEPTH];
    logic [W-1:0]  exp_rs1, exp_rs2, ack_data;
    bit            v_rs1, v_rs2;
    int            waited;
    bit            ack_now, ack_rd;
    bit            dbg_pending, dbg_wr_s;
    logic [AW-1:0] dbg_addr_s;
    logic [W-1:0]  dbg_wdata_s;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) arch[i] = '0;
        v_rs1 = 0; v_rs2 = 0; waited = 0;
        ack_now = 0; ack_rd = 0; dbg_pending = 0;
    endtask

    // Assert reset asynchronously and check the reset-time outputs
    task automatic start_reset();
        rst_n        = 1'b0;
        bus.rs1_req  = 1'b1; bus.rs1_addr = AW'(3);
        bus.rs2_req  = 1'b1; bus.rs2_addr = AW'(4);
        bus.rd_write = 1'b1; bus.rd_addr  = AW'(5); bus.rd_wdata = 32'h5555_AAAA;
        bus.dbg_req  = 1'b0; bus.dbg_write = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
        model_reset();
        #1;
        chk("rst_ready",     W'(bus.ready),      '0);
        chk("rst_dbg_ack",   W'(bus.dbg_ack),    '0);
        chk("rst_dbg_rdata", bus.dbg_rdata,      '0);
        chk("rst_clr_addr",  W'(bus.rf_rd_addr), W'(1));
    endtask

    // Release reset at the next falling edge and check clear writes 1..last
    task automatic clear_seq(input int last);
        for (int i = 1; i <= last; i++) begin
            @(negedge clk);
            if (i == 1) rst_n = 1'b1;
            #1;
            chk("clr_we",    W'(bus.rf_rd_write), W'(1));
            chk("clr_addr",  W'(bus.rf_rd_addr),  W'(i));
            chk("clr_wdata", bus.rf_rd_wdata,     '0);
            chk("clr_reads", W'({bus.rf_rs1_read, bus.rf_rs2_read}), '0);
            chk("clr_ready", W'(bus.ready),   '0);
            chk("clr_ack",   W'(bus.dbg_ack), '0);
        end
    endtask

    task automatic dbg_start(input bit wr, input logic [AW-1:0] a, input logic [W-1:0] d);
        dbg_pending = 1; dbg_wr_s = wr; dbg_addr_s = a; dbg_wdata_s = d;
    endtask

    // One RUN-phase cycle: drive, check against the reference, advance the reference
    task automatic core_cycle(input bit r1, input logic [AW-1:0] a1,
                              input bit r2, input logic [AW-1:0] a2,
                              input bit wr, input logic [AW-1:0] wa, input logic [W-1:0] wd);
        bit   exp_ready, g_rd, g_wr, exp_we, exp_r1;
        @(negedge clk);
        bus.rs1_req = r1; bus.rs1_addr = a1;
        bus.rs2_req = r2; bus.rs2_addr = a2;
        bus.rd_write = wr; bus.rd_addr = wa; bus.rd_wdata = wd;
        bus.dbg_req = dbg_pending;
        bus.dbg_write = dbg_wr_s;
        if (dbg_pending && !ack_now) begin
            bus.dbg_addr = dbg_addr_s; bus.dbg_wdata = dbg_wdata_s;
        end else begin
            bus.dbg_addr = AW'($urandom); bus.dbg_wdata = $urandom;
        end
        #1;
        exp_ready = ack_now || !(dbg_pending && waited == int'(LIMIT));
        g_rd = !ack_now && dbg_pending && !dbg_wr_s && (!r1 || !exp_ready);
        g_wr = !ack_now && dbg_pending &&  dbg_wr_s && (!wr || !exp_ready);
        exp_we = (exp_ready && wr && wa != '0) || (g_wr && dbg_addr_s != '0);
        exp_r1 = (exp_ready && r1) || g_rd;

        chk("ready",       W'(bus.ready),       W'(exp_ready));
        chk("dbg_ack",     W'(bus.dbg_ack),     W'(ack_now));
        if (ack_now && ack_rd) chk("dbg_rdata", bus.dbg_rdata, ack_data);
        if (v_rs1) chk("rs1_rdata", bus.rs1_rdata, exp_rs1);
        if (v_rs2) chk("rs2_rdata", bus.rs2_rdata, exp_rs2);
        chk("rf_rd_write", W'(bus.rf_rd_write), W'(exp_we));
        chk("rf_rs1_read", W'(bus.rf_rs1_read), W'(exp_r1));
        chk("rf_rs2_read", W'(bus.rf_rs2_read), W'(exp_ready && r2));
        if (g_rd) chk("dbg_rd_addr", W'(bus.rf_rs1_addr), W'(dbg_addr_s));
        if (exp_we && g_wr) chk("dbg_wr_data", bus.rf_rd_wdata, dbg_wdata_s);

        if (exp_ready && wr && wa != '0) arch[wa] = wd;
        if (g_wr && dbg_addr_s != '0)    arch[dbg_addr_s] = dbg_wdata_s;
        if (exp_ready && r1) begin exp_rs1 = arch[a1]; v_rs1 = 1; end
        if (exp_ready && r2) begin exp_rs2 = arch[a2]; v_rs2 = 1; end
        if (g_rd) begin exp_rs1 = arch[dbg_addr_s]; v_rs1 = 1; ack_data = exp_rs1; end

        if (g_rd || g_wr)                waited = 0;
        else if (!ack_now && dbg_pending) waited++;
        if (ack_now) dbg_pending = 0;
        ack_now = g_rd || g_wr;
        ack_rd  = g_rd;
    endtask

    task automatic idle();
        core_cycle(0, '0, 0, '0, 0, '0, '0);
    endtask

    initial begin
        for (int i = 1; i < int'(DEPTH); i++) mem[i] <= $urandom;
        mem[0] <= '0;
        #2;
        start_reset();
        repeat (2) @(negedge clk);
        clear_seq(31);

        // readback after clear: everything reads 0, ready from cycle 32
        for (int i = 0; i < int'(DEPTH); i++) core_cycle(1, AW'(i), 1, AW'(31 - i), 0, '0, '0);
        idle();

        // write+read same register same cycle, then hold
        core_cycle(1, AW'(5), 1, AW'(5), 1, AW'(5), 32'hA5A5_A5A5);
        repeat (3) idle();

        // writes to register 0 are dropped
        core_cycle(0, '0, 0, '0, 1, '0, 32'hFFFF_FFFF);
        core_cycle(1, '0, 1, '0, 0, '0, '0);
        idle();

        // debug read of reg 7 granted at once, acked next cycle
        core_cycle(0, '0, 0, '0, 1, AW'(7), 32'h12);
        dbg_start(0, AW'(7), 32'hDEAD_BEEF);
        idle();
        idle();
        chk("req022_ack_seen", W'(ack_now), '0);

        // starvation: forced grant on the 9th request cycle, ack on the 10th
        dbg_start(0, AW'(9), '0);
        for (int k = 1; k <= 10; k++) begin
            core_cycle(1, AW'($urandom), 0, '0, 0, '0, '0);
            chk("starve_ready", W'(bus.ready),   W'(k != 9));
            chk("starve_ack",   W'(bus.dbg_ack), W'(k == 10));
        end

        // debug write to register 0: dropped but acknowledged
        dbg_start(1, '0, 32'hCAFE_0000);
        idle();
        idle();
        core_cycle(1, '0, 0, '0, 0, '0, '0);
        idle();

        // randomized traffic on a narrow address window to force collisions
        for (int n = 0; n < 1500; n++) begin
            if (!dbg_pending && $urandom_range(0, 3) == 0)
                dbg_start(1'($urandom), AW'($urandom_range(0, 7)), $urandom);
            core_cycle(1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, 7)),
                       1'($urandom),                  AW'($urandom_range(0, 7)),
                       1'($urandom),                  AW'($urandom_range(0, 7)), $urandom);
        end
        while (dbg_pending) idle();

        // reset in the grant cycle of a debug write: no ack, full clear follows
        dbg_start(1, AW'(3), 32'h3333_3333);
        idle();
        #2;
        start_reset();
        @(negedge clk);
        #1;
        chk("abort_no_ack", W'(bus.dbg_ack), '0);
        clear_seq(31);
        core_cycle(1, AW'(3), 0, '0, 0, '0, '0);
        idle();

        // reset mid-clear at address 12 restarts the clear from address 1
        start_reset();
        clear_seq(12);
        #2;
        start_reset();
        clear_seq(31);
        for (int i = 0; i < 8; i++) core_cycle(1, AW'(i), 1, AW'(i + 8), 0, '0, '0);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/armleo_regfile_ctrl.md
ARMLEO_REGFILE_CTRL -- requirements
Module: armleo_regfile_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, register width in bits.
REQ-002 SHALL have parameter DEPTH_LOG2, default 5, register address width; DEPTH = 2**DEPTH_LOG2.
REQ-003 SHALL have parameter STARVE_LIMIT, default 8, cycles of denied debug request before a forced grant.
REQ-004 SHALL have ports:
 - clk  in  1  sole clock, rising edge.
 - rst_n  in  1  asynchronous, active-low reset.
 - ready  out  1  core side: core requests accepted this cycle.
 - rs1_req / rs2_req  in  1  core read request.
 - rs1_addr / rs2_addr  in  DEPTH_LOG2  core read address.
 - rs1_rdata / rs2_rdata  out  WIDTH  read data, valid the cycle after the accepted request.
 - rd_write  in  1  core write request.
 - rd_addr  in  DEPTH_LOG2  core write address.
 - rd_wdata  in  WIDTH  core write data.
 - dbg_req  in  1  debug access request, held until dbg_ack.
 - dbg_write  in  1  1 = write, 0 = read.
 - dbg_addr  in  DEPTH_LOG2  debug address.
 - dbg_wdata  in  WIDTH  debug write data.
 - dbg_ack  out  1  one-cycle completion pulse.
 - dbg_rdata  out  WIDTH  debug read data, valid while dbg_ack=1.
 - rf_rs1_read / rf_rs2_read  out  1  regfile read enables.
 - rf_rs1_addr / rf_rs2_addr  out  DEPTH_LOG2  regfile read addresses.
 - rf_rs1_rdata / rf_rs2_rdata  in  WIDTH  regfile read data; synchronous, old data on same-address same-cycle write.
 - rf_rd_write  out  1  regfile write enable.
 - rf_rd_addr  out  DEPTH_LOG2  regfile write address.
 - rf_rd_wdata  out  WIDTH  regfile write data.

Function
REQ-005 SHALL implement FSM states CLEAR, RUN, DBG_ACK.
REQ-006 CLEAR SHALL write 0 to registers 1..DEPTH-1, one per cycle, ascending (rf_rd_write=1, rf_rd_wdata=0), with rf read enables 0 and ready=0; after writing DEPTH-1 it SHALL go to RUN (DEPTH-1 cycles total).
REQ-007 In RUN with ready=1, core requests SHALL pass straight through to the rf_* ports in the same cycle; writes to address 0 SHALL be forwarded with rf_rd_write=0.
REQ-008 When ready=0, all core requests SHALL be ignored (no rf access, no bypass update).
REQ-009 Bypass: if a read is issued to rf on port N in cycle C, a write is issued in cycle C, addresses match and are nonzero, then rsN_rdata in cycle C+1 SHALL be the written data; otherwise rsN_rdata SHALL equal rf_rsN_rdata.
REQ-010 The bypass selection SHALL hold until the next issued read on that port.
REQ-011 Debug grant in RUN: a read SHALL be granted when dbg_req=1 and the core is not using port 1 (rs1_req=0 or ready=0); a write SHALL be granted when rd_write=0 or ready=0.
REQ-012 A granted debug read SHALL use port 1; a granted debug write SHALL use the write port; a debug write to address 0 SHALL be dropped but still acknowledged.
REQ-013 After a grant, FSM SHALL enter DBG_ACK for exactly one cycle: dbg_ack=1, dbg_rdata = read data (bypass rules apply), then return to RUN; no debug grant in DBG_ACK, while core traffic continues with ready=1.
REQ-014 A starvation counter SHALL increment each RUN cycle with dbg_req=1 and no grant, and clear on grant.
REQ-015 When the starvation counter equals STARVE_LIMIT, ready SHALL be 0 that cycle and the debug request SHALL be granted.
REQ-016 dbg_wdata and dbg_addr SHALL be sampled only in the grant cycle.

Reset
REQ-017 rst_n low SHALL asynchronously force: state CLEAR, clear counter 1, starvation counter 0, bypass flags 0, ready 0, dbg_ack 0, dbg_rdata 0.
REQ-018 Reset mid-CLEAR or mid-debug SHALL abort the operation without an ack; the full clear SHALL restart after release.

Verification
REQ-019 Release reset with DEPTH_LOG2=5 -> 31 writes of 0 to addresses 1..31, then ready=1 on cycle 32; all registers read back 0.
REQ-020 Core writes reg 5=0xA5A5A5A5 while reading rs1=5 and rs2=5 in the same cycle -> both rdata = 0xA5A5A5A5 the next cycle, held until the next read.
REQ-021 Core writes reg 0 = 0xFFFFFFFF, then reads reg 0 -> rf_rd_write=0, rdata=0.
REQ-022 Debug read reg 7 (=0x12) with rs1_req=0 -> grant same cycle, dbg_ack=1 and dbg_rdata=0x12 next cycle.
REQ-023 rs1_req=1 every cycle plus pending debug read -> ready=0 on the 9th request cycle (STARVE_LIMIT=8), dbg_ack on the 10th.
REQ-024 Assert rst_n low during CLEAR at address 12 -> after release, clear restarts at address 1, no dbg_ack.
